reorder_tag_scheduler: RTL and testbench

Owns the reorder-tag lifecycle for the circular packet buffer. It hands out in-order reorder tags to packets entering from the forwarder, and records accept/reject verdicts from the filter cores in a status table. It presents the status of the head-of-line tag to the buffer and frees that tag when the buffer retires it. Sits between the forwarder/filter cores and the circular buffer, and replaces the buffer's external memory table.

---
 rtl/reorder_tag_scheduler.sv | 130 +++++++++++++
 tb/tb_reorder_tag_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reorder_tag_scheduler.sv
// Reorder-tag scheduler for the circular packet buffer.
//
// Hands out reorder tags in allocation order, records filter verdicts in a
// per-tag status table, and exposes the head-of-line tag and its status to
// the buffer. The buffer retires the head tag once it has been sent or skipped.
//
// Status encoding: 00 free, 10 pending, 11 accepted, 01 rejected.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   alloc_req                forwarder requests a tag
//   alloc_gnt, alloc_tag     combinational grant and the granted tag
//   verdict_valid/_tag/_accept  filter verdict for a pending tag
//   head_tag, packet_status  oldest outstanding tag and its status
//   retire                   buffer finished or skipped the head packet
//   occupancy, full, empty   outstanding-tag count and its flags
//   err_sticky               protocol violation seen since reset
module reorder_tag_scheduler #(
  parameter int unsigned TAG_WIDTH = 6,
  parameter int unsigned NUM_TAGS  = 50,
  parameter int unsigned CNT_WIDTH = $clog2(NUM_TAGS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  input  logic                 verdict_valid,
  input  logic [TAG_WIDTH-1:0] verdict_tag,
  input  logic                 verdict_accept,
  output logic [TAG_WIDTH-1:0] head_tag,
  output logic [1:0]           packet_status,
  input  logic                 retire,
  output logic [CNT_WIDTH-1:0] occupancy,
  output logic                 full,
  output logic                 empty,
  output logic                 err_sticky
);

  typedef logic [TAG_WIDTH-1:0] tag_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam tag_t       LastTag = tag_t'(NUM_TAGS - 1);
  localparam cnt_t       MaxOcc  = cnt_t'(NUM_TAGS);
  localparam logic [1:0] StFree  = 2'b00;
  localparam logic [1:0] StPend  = 2'b10;
  localparam logic [1:0] StAcc   = 2'b11;
  localparam logic [1:0] StRej   = 2'b01;

  logic [1:0] status_q [NUM_TAGS];
  logic [1:0] status_d [NUM_TAGS];
  tag_t       tail_q, tail_d;
  tag_t       head_q, head_d;
  cnt_t       occ_q, occ_d;
  logic       err_q, err_d;

  logic [1:0] head_status;
  logic [1:0] verdict_status;
  logic       verdict_ok;
  logic       retire_ok;

  assign full          = (occ_q == MaxOcc);
  assign empty         = (occ_q == '0);
  assign occupancy     = occ_q;
  assign alloc_gnt     = alloc_req && !full;
  assign alloc_tag     = tail_q;
  assign head_tag      = head_q;
  assign packet_status = head_status;
  assign err_sticky    = err_q;

  // Explicit compare muxes: tags at or above NUM_TAGS read back as free, so an
  // out-of-range verdict falls into the "not pending" error path.
  always_comb begin
    head_status    = StFree;
    verdict_status = StFree;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      if (head_q == tag_t'(i)) head_status = status_q[i];
      if (verdict_tag == tag_t'(i)) verdict_status = status_q[i];
    end
  end

  // Decided states (11, 01) both have bit 0 set.
  assign retire_ok  = retire && head_status[0];
  // A verdict on the tag being granted this cycle sees it still free, and a
  // verdict on the head being retired sees it already decided; both are errors.
  assign verdict_ok = verdict_valid && (verdict_status == StPend);

  always_comb begin
    status_d = status_q;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      if (alloc_gnt && (tail_q == tag_t'(i))) status_d[i] = StPend;
      if (verdict_ok && (verdict_tag == tag_t'(i))) begin
        status_d[i] = verdict_accept ? StAcc : StRej;
      end
      if (retire_ok && (head_q == tag_t'(i))) status_d[i] = StFree;
    end
  end

  always_comb begin
    tail_d = tail_q;
    head_d = head_q;
    occ_d  = occ_q;
    err_d  = err_q;
    if (alloc_gnt) tail_d = (tail_q == LastTag) ? '0 : tail_q + tag_t'(1);
    if (retire_ok) head_d = (head_q == LastTag) ? '0 : head_q + tag_t'(1);
    case ({alloc_gnt, retire_ok})
      2'b10:   occ_d = occ_q + cnt_t'(1);
      2'b01:   occ_d = occ_q - cnt_t'(1);
      default: occ_d = occ_q;
    endcase
    if ((verdict_valid && !verdict_ok) || (retire && !retire_ok)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_TAGS; i++) status_q[i] <= StFree;
      tail_q <= '0;
      head_q <= '0;
      occ_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      status_q <= status_d;
      tail_q   <= tail_d;
      head_q   <= head_d;
      occ_q    <= occ_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_reorder_tag_scheduler.sv
// Scoreboard bench for reorder_tag_scheduler (default parameters).
// Stimulus pushes expected grant tags and per-cycle state snapshots into
// queues; a monitor on the falling edge pops and compares them.
module tb_reorder_tag_scheduler;

  logic       clk;
  logic       rst;
  logic       alloc_req;
  logic       alloc_gnt;
  logic [5:0] alloc_tag;
  logic       verdict_valid;
  logic [5:0] verdict_tag;
  logic       verdict_accept;
  logic [5:0] head_tag;
  logic [1:0] packet_status;
  logic       retire;
  logic [5:0] occupancy;
  logic       full;
  logic       empty;
  logic       err_sticky;

  reorder_tag_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_req     (alloc_req),
    .alloc_gnt     (alloc_gnt),
    .alloc_tag     (alloc_tag),
    .verdict_valid (verdict_valid),
    .verdict_tag   (verdict_tag),
    .verdict_accept(verdict_accept),
    .head_tag      (head_tag),
    .packet_status (packet_status),
    .retire        (retire),
    .occupancy     (occupancy),
    .full          (full),
    .empty         (empty),
    .err_sticky    (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       gnt;
    logic [5:0] tag;
    logic [5:0] head;
    logic [1:0] st;
    int         occ;
    logic       full;
    logic       empty;
    logic       err;
  } snap_t;

  snap_t sq[$];
  int    gq[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input int c, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, c, act, exp);
    end
  endtask

  // Monitor: grant queue popped on every DUT grant; snapshots by cycle stamp.
  always @(negedge clk) begin
    if (alloc_gnt === 1'b1) begin
      if (gq.size() == 0) begin
        chk("unexpected_grant", cyc, 1, 0);
      end else begin
        int t;
        t = gq.pop_front();
        chk("grant_tag", cyc, int'(alloc_tag), t);
      end
    end
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      snap_t s;
      s = sq.pop_front();
      chk("snapshot_stale", cyc, s.cyc, cyc);
      chk("alloc_gnt", cyc, int'(alloc_gnt), int'(s.gnt));
      chk("alloc_tag", cyc, int'(alloc_tag), int'(s.tag));
      chk("head_tag", cyc, int'(head_tag), int'(s.head));
      chk("packet_status", cyc, int'(packet_status), int'(s.st));
      chk("occupancy", cyc, int'(occupancy), s.occ);
      chk("full", cyc, int'(full), int'(s.full));
      chk("empty", cyc, int'(empty), int'(s.empty));
      chk("err_sticky", cyc, int'(err_sticky), int'(s.err));
    end
  end

  task automatic eg(input int tag);
    gq.push_back(tag);
  endtask

  task automatic sn(input logic g, input int tag, input int head, input logic [1:0] st,
                    input int occ, input logic f, input logic e, input logic err);
    snap_t s;
    s.cyc = cyc; s.gnt = g; s.tag = 6'(tag); s.head = 6'(head); s.st = st;
    s.occ = occ; s.full = f; s.empty = e; s.err = err;
    sq.push_back(s);
  endtask

  task automatic st(input logic req, input logic vv, input int vtag, input logic vacc,
                    input logic ret);
    @(posedge clk);
    #1;
    alloc_req      = req;
    verdict_valid  = vv;
    verdict_tag    = 6'(vtag);
    verdict_accept = vacc;
    retire         = ret;
  endtask

  task automatic idle();
    st(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(posedge clk);
    #1;
    alloc_req = 1'b0; verdict_valid = 1'b0; verdict_tag = '0;
    verdict_accept = 1'b0; retire = 1'b0;
    rst = 1'b0;
    sn(0, 0, 0, 2'b00, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; alloc_req = 1'b0; verdict_valid = 1'b0; verdict_tag = '0;
    verdict_accept = 1'b0; retire = 1'b0;

    // Basic allocate / verdict / retire
    do_reset();
    st(1, 0, 0, 0, 0); eg(0); sn(1, 0, 0, 2'b00, 0, 0, 1, 0);
    st(1, 0, 0, 0, 0); eg(1); sn(1, 1, 0, 2'b10, 1, 0, 0, 0);
    st(1, 0, 0, 0, 0); eg(2); sn(1, 2, 0, 2'b10, 2, 0, 0, 0);
    st(0, 1, 1, 1, 0);        sn(0, 3, 0, 2'b10, 3, 0, 0, 0);
    st(0, 1, 0, 0, 0);        sn(0, 3, 0, 2'b10, 3, 0, 0, 0);
    st(0, 0, 0, 0, 1);        sn(0, 3, 0, 2'b01, 3, 0, 0, 0);
    st(0, 0, 0, 0, 1);        sn(0, 3, 1, 2'b11, 2, 0, 0, 0);
    idle();                   sn(0, 3, 2, 2'b10, 1, 0, 0, 0);

    // Grant, verdict and retire in the same cycle
    do_reset();
    st(1, 0, 0, 0, 0); eg(0); sn(1, 0, 0, 2'b00, 0, 0, 1, 0);
    st(1, 0, 0, 0, 0); eg(1); sn(1, 1, 0, 2'b10, 1, 0, 0, 0);
    st(1, 0, 0, 0, 0); eg(2); sn(1, 2, 0, 2'b10, 2, 0, 0, 0);
    st(0, 1, 0, 1, 0);        sn(0, 3, 0, 2'b10, 3, 0, 0, 0);
    st(1, 1, 1, 1, 1); eg(3); sn(1, 3, 0, 2'b11, 3, 0, 0, 0);
    st(0, 1, 3, 1, 0);        sn(0, 4, 1, 2'b11, 3, 0, 0, 0);
    st(0, 0, 0, 0, 1);        sn(0, 4, 1, 2'b11, 3, 0, 0, 0);
    idle();                   sn(0, 4, 2, 2'b10, 2, 0, 0, 0);
    st(0, 0, 0, 0, 1);        sn(0, 4, 2, 2'b10, 2, 0, 0, 0);
    idle();                   sn(0, 4, 2, 2'b10, 2, 0, 0, 1);

    // Verdict on a free tag, then retire while head is pending
    do_reset();
    st(0, 1, 5, 1, 0);        sn(0, 0, 0, 2'b00, 0, 0, 1, 0);
    idle();                   sn(0, 0, 0, 2'b00, 0, 0, 1, 1);
    st(1, 0, 0, 0, 0); eg(0); sn(1, 0, 0, 2'b00, 0, 0, 1, 1);
    st(0, 0, 0, 0, 1);        sn(0, 1, 0, 2'b10, 1, 0, 0, 1);
    idle();                   sn(0, 1, 0, 2'b10, 1, 0, 0, 1);

    // Verdict on the tag granted in the same cycle; out-of-range verdict
    do_reset();
    st(1, 1, 0, 1, 0); eg(0); sn(1, 0, 0, 2'b00, 0, 0, 1, 0);
    idle();                   sn(0, 1, 0, 2'b10, 1, 0, 0, 1);
    do_reset();
    st(0, 1, 55, 0, 0);       sn(0, 0, 0, 2'b00, 0, 0, 1, 0);
    idle();                   sn(0, 0, 0, 2'b00, 0, 0, 1, 1);

    // Fill to NUM_TAGS, blocked grant, wrap-around grant after retire
    do_reset();
    for (int i = 0; i < 50; i++) begin
      st(1, 0, 0, 0, 0); eg(i);
      sn(1, i, 0, (i == 0) ? 2'b00 : 2'b10, i, 0, (i == 0), 0);
    end
    st(1, 0, 0, 0, 0);        sn(0, 0, 0, 2'b10, 50, 1, 0, 0);
    st(1, 1, 0, 1, 0);        sn(0, 0, 0, 2'b10, 50, 1, 0, 0);
    st(1, 0, 0, 0, 1);        sn(0, 0, 0, 2'b11, 50, 1, 0, 0);
    st(1, 0, 0, 0, 0); eg(0); sn(1, 0, 1, 2'b10, 49, 0, 0, 0);
    idle();                   sn(0, 1, 1, 2'b10, 50, 1, 0, 0);

    // Reset mid-stream with 7 outstanding
    do_reset();
    for (int i = 0; i < 7; i++) begin
      st(1, 0, 0, 0, 0); eg(i);
      sn(1, i, 0, (i == 0) ? 2'b00 : 2'b10, i, 0, (i == 0), 0);
    end
    idle();                   sn(0, 7, 0, 2'b10, 7, 0, 0, 0);
    do_reset();
    st(1, 0, 0, 0, 0); eg(0); sn(1, 0, 0, 2'b00, 0, 0, 1, 0);
    idle();                   sn(0, 1, 0, 2'b10, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("grants_outstanding", cyc, gq.size(), 0);
    chk("snapshots_outstanding", cyc, sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
